axi_lite_rd_arb: RTL and testbench
==================================

Name: axi_lite_rd_arb

Overview:
- Parametrised N-master to 1-slave AXI4-Lite read-channel arbiter with an in-order outstanding-read tracker.
- Lets the IFU fetch port and the LSU load port, plus future masters, share one memory read port instead of one memory instance per unit.
- The AR channel is registered, so the arbiter acts as a slice. R responses are routed back by a FIFO of master indices.
- Arbitration is fixed-priority or round-robin, selected by parameter.

Parameters:
N_MST, 2, number of masters (>=1); master 0 = IFU, master 1 = LSU by convention
ADDR_W, 32, address width
DATA_W, 64, read data width
DEPTH, 4, max reads in flight; power of 2, >=2
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
IDX_W, derived, max(1, clog2(N_MST))

Ports:
AXI_ACLK  in  1  clock
AXI_ARESETN  in  1  asynchronous active-low reset
M_ARADDR  in  N_MST*ADDR_W  master AR addresses, master i at [i*ADDR_W +: ADDR_W]
M_ARVALID  in  N_MST  master AR valid
M_ARREADY  out  N_MST  master AR ready
M_RDATA  out  N_MST*DATA_W  read data, replicated to all masters
M_RRESP  out  N_MST*2  read response, replicated to all masters
M_RVALID  out  N_MST  read valid, one-hot to the owning master
M_RREADY  in  N_MST  master R ready
S_ARADDR  out  ADDR_W  slave AR address
S_ARVALID  out  1  slave AR valid
S_ARREADY  in  1  slave AR ready
S_RDATA  in  DATA_W  slave read data
S_RRESP  in  2  slave read response
S_RVALID  in  1  slave read valid
S_RREADY  out  1  slave R ready
rd_inflight  out  clog2(DEPTH)+1  reads accepted by slave and not yet completed
rd_err  out  1  sticky flag: unexpected R beat

Behaviour:
- Reset (async, AXI_ARESETN=0):
  - outputs: S_ARVALID=0, S_ARADDR=0, M_ARREADY=0, M_RVALID=0, S_RREADY=0, rd_inflight=0, rd_err=0.
  - state: FSM=AR_IDLE, RR pointer=0, FIFO emptied.
  - Release is synchronous to AXI_ACLK.
- AR FSM, state AR_IDLE:
  - Arbitration condition: any M_ARVALID and FIFO count < DEPTH.
  - When it holds, pick winner w and assert M_ARREADY[w]=1 combinationally in the same cycle; no other M_ARREADY is asserted.
  - On the clock edge, latch M_ARADDR[w] into S_ARADDR, latch w into sel, go to AR_BUSY.
- AR FSM, state AR_BUSY:
  - S_ARVALID=1, S_ARADDR is stable, all M_ARREADY=0.
  - On S_ARVALID & S_ARREADY: push sel into FIFO and return to AR_IDLE.
  - Peak rate is 1 AR per 2 cycles. Master-to-slave AR latency is 1 cycle minimum.
- Winner selection:
  - Fixed mode: lowest requesting index.
  - RR mode: first requester scanning ptr, ptr+1, ... modulo N_MST. After each master handshake, ptr = (w+1) mod N_MST.
  - N_MST=1: always index 0, ptr unused.
- FIFO full (count==DEPTH): AR_IDLE grants nothing and M_ARREADY stays 0; requests wait without loss.
- R path, FIFO non-empty, head h:
  - M_RVALID[h]=S_RVALID; S_RREADY=M_RREADY[h].
  - M_RDATA and M_RRESP are S_RDATA and S_RRESP replicated to every master.
  - The response path is purely combinational, 0-cycle.
  - On S_RVALID & S_RREADY: pop.
- R path, FIFO empty: S_RREADY=0 and all M_RVALID=0. If S_RVALID=1 in this state, set rd_err=1; it stays set until reset.
- Push and pop in the same cycle: count unchanged, pointers both advance. Pointers wrap modulo DEPTH.
- rd_inflight equals FIFO count, registered.
- Responses are strictly in-order, matching AXI4-Lite slave ordering. No reordering and no per-master limit.
- A master dropping M_ARVALID after being granted has no effect: the address is already latched.

Decomposition:
- Shared package (common.v defines):
  - AXI RESP codes OKAY=2'b00, SLVERR=2'b10.
  - ARB_FIXED=0 and ARB_RR=1.
  - AR FSM state encodings AR_IDLE and AR_BUSY.
- Sub-module rd_id_fifo: parametrised DATA_W=IDX_W, DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Asynchronous active-low reset.
  - Instantiated once.

Test Plan:
- Reset mid-flight: 3 reads in flight, pulse AXI_ARESETN low -> S_ARVALID=0, rd_inflight=0, next R beat with no AR raises rd_err=1.
- Single master: M0 ARADDR=0x8000_0000, slave ARREADY=1, RDATA=0x1122334455667788 -> M_ARREADY[0] on cycle 0, S_ARVALID cycle 1, M_RVALID[0] with that data, M_RVALID[1]=0.
- Round-robin (ARB_MODE=1): M0 and M1 request continuously, 6 grants -> order 0,1,0,1,0,1. Fixed mode (ARB_MODE=0), same stimulus -> 0,0,0,0,0,0 while M0 holds valid.
- Full FIFO (DEPTH=4): slave ARREADY=1, RVALID=0, 5 requests -> 4 accepted, rd_inflight=4, 5th M_ARREADY stays 0 until one R completes, then granted.
- In-order routing: AR order M1,M0,M1 with slave returning D0,D1,D2 -> M1 gets D0, M0 gets D1, M1 gets D2. With M_RREADY[1]=0 for 3 cycles -> S_RREADY=0 and data held.
- Simultaneous push/pop at count=2: AR handshake and R handshake in the same cycle -> rd_inflight stays 2, routing stays correct.

Source files
------------

// File: rtl/axi_lite_rd_arb_pkg.sv
// Shared definitions for the AXI4-Lite read arbiter: response codes, arbitration
// modes, AR FSM encodings and the index-width helper.
package axi_lite_rd_arb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  // A single master still needs a 1-bit index so every vector stays legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_rd_arb_if.sv
// Bundled AR/R signals for the N-master side and the shared slave port.
// master: the arbiter's view; slave: the masters plus the memory around it.
interface axi_lite_rd_arb_if #(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [N_MST*ADDR_W-1:0] M_ARADDR;
  logic [N_MST-1:0]        M_ARVALID;
  logic [N_MST-1:0]        M_ARREADY;
  logic [N_MST*DATA_W-1:0] M_RDATA;
  logic [N_MST*2-1:0]      M_RRESP;
  logic [N_MST-1:0]        M_RVALID;
  logic [N_MST-1:0]        M_RREADY;

  logic [ADDR_W-1:0]       S_ARADDR;
  logic                    S_ARVALID;
  logic                    S_ARREADY;
  logic [DATA_W-1:0]       S_RDATA;
  logic [1:0]              S_RRESP;
  logic                    S_RVALID;
  logic                    S_RREADY;

  modport master (
    input  M_ARADDR, M_ARVALID, M_RREADY, S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
    output M_ARREADY, M_RDATA, M_RRESP, M_RVALID, S_ARADDR, S_ARVALID, S_RREADY
  );

  modport slave (
    output M_ARADDR, M_ARVALID, M_RREADY, S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
    input  M_ARREADY, M_RDATA, M_RRESP, M_RVALID, S_ARADDR, S_ARVALID, S_RREADY
  );
endinterface

// File: rtl/axi_lite_rd_arb_rd_id_fifo.sv
// Small FIFO of master indices recording the order reads were issued to the slave.
module rd_id_fifo #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         push_en, pop_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axi_lite_rd_arb.sv
// N-master to 1-slave AXI4-Lite read arbiter: registered AR slice with fixed or
// round-robin selection, in-order R routing through a FIFO of master indices.
module axi_lite_rd_arb
  import axi_lite_rd_arb_pkg::*;
#(
  parameter int N_MST    = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 1
) (
  input  logic                   AXI_ACLK,
  input  logic                   AXI_ARESETN,
  axi_lite_rd_arb_if.master      bus,
  output logic [$clog2(DEPTH):0] rd_inflight,
  output logic                   rd_err
);
  localparam int IDX_W = idx_w(N_MST);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  ar_state_e         state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              rd_err_q, rd_err_d;

  logic [IDX_W-1:0]  win;
  logic              win_found;
  logic [N_MST-1:0]  arready;
  logic [N_MST-1:0]  rvalid;
  logic              rready;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IDX_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  // Winner search: RR scans from ptr upward with wrap, fixed scans from 0.
  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    win       = '0;
    win_found = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < N_MST; k++) begin
      j  = (ARB_MODE == ARB_RR) ? ((int'(ptr_q) + k) % N_MST) : k;
      jj = IDX_W'(j);
      if (!win_found && bus.M_ARVALID[jj]) begin
        win       = jj;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    araddr_d  = araddr_q;
    arready   = '0;
    fifo_push = 1'b0;
    case (state_q)
      AR_IDLE: begin
        // Gate on reset so no grant leaks out while the block is held in reset.
        if (AXI_ARESETN && win_found && !fifo_full) begin
          arready[win] = 1'b1;
          araddr_d     = bus.M_ARADDR[int'(win)*ADDR_W +: ADDR_W];
          sel_d        = win;
          state_d      = AR_BUSY;
          if (ARB_MODE == ARB_RR)
            ptr_d = (int'(win) == N_MST - 1) ? '0 : win + IDX_W'(1);
        end
      end
      AR_BUSY: begin
        if (bus.S_ARREADY) begin
          fifo_push = 1'b1;
          state_d   = AR_IDLE;
        end
      end
      default: state_d = AR_IDLE;
    endcase
  end

  // Response path is pure wiring steered by the oldest outstanding index.
  always_comb begin
    rvalid   = '0;
    rready   = 1'b0;
    rd_err_d = rd_err_q;
    if (!fifo_empty) begin
      rvalid[fifo_head] = bus.S_RVALID;
      rready            = bus.M_RREADY[fifo_head];
    end else if (bus.S_RVALID) begin
      rd_err_d = 1'b1;
    end
    fifo_pop = ~fifo_empty & bus.S_RVALID & rready;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q  <= AR_IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      araddr_q <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      araddr_q <= araddr_d;
      rd_err_q <= rd_err_d;
    end
  end

  rd_id_fifo #(
    .DATA_W (IDX_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (AXI_ACLK),
    .rst_n (AXI_ARESETN),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sel_q),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.M_ARREADY = arready;
  assign bus.S_ARVALID = (state_q == AR_BUSY);
  assign bus.S_ARADDR  = araddr_q;
  assign bus.M_RVALID  = rvalid;
  assign bus.S_RREADY  = rready;
  assign bus.M_RDATA   = {N_MST{bus.S_RDATA}};
  assign bus.M_RRESP   = {N_MST{bus.S_RRESP}};
  assign rd_inflight   = fifo_count;
  assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_axi_lite_rd_arb.sv
// Directed bench: a round-robin and a fixed-priority instance share one stimulus;
// a cycle table covers arbitration/routing, hand sequences cover the corner cases.
module tb_axi_lite_rd_arb;
  import axi_lite_rd_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_rd_arb_if #(.N_MST(2), .ADDR_W(32), .DATA_W(64)) if_rr ();
  axi_lite_rd_arb_if #(.N_MST(2), .ADDR_W(32), .DATA_W(64)) if_fx ();

  assign if_fx.M_ARADDR  = if_rr.M_ARADDR;
  assign if_fx.M_ARVALID = if_rr.M_ARVALID;
  assign if_fx.M_RREADY  = if_rr.M_RREADY;
  assign if_fx.S_ARREADY = if_rr.S_ARREADY;
  assign if_fx.S_RDATA   = if_rr.S_RDATA;
  assign if_fx.S_RRESP   = if_rr.S_RRESP;
  assign if_fx.S_RVALID  = if_rr.S_RVALID;

  logic [2:0] infl_rr, infl_fx;
  logic       err_rr, err_fx;

  axi_lite_rd_arb #(.N_MST(2), .ADDR_W(32), .DATA_W(64), .DEPTH(4), .ARB_MODE(1)) u_rr (
    .AXI_ACLK(clk), .AXI_ARESETN(rst_n), .bus(if_rr.master),
    .rd_inflight(infl_rr), .rd_err(err_rr));

  axi_lite_rd_arb #(.N_MST(2), .ADDR_W(32), .DATA_W(64), .DEPTH(4), .ARB_MODE(0)) u_fx (
    .AXI_ACLK(clk), .AXI_ARESETN(rst_n), .bus(if_fx.master),
    .rd_inflight(infl_fx), .rd_err(err_fx));

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_1000;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] av;
    logic       srv;
    logic [1:0] ar_rr;
    logic [1:0] ar_fx;
    logic [1:0] rv_rr;
    logic [1:0] rv_fx;
    logic       s_arv;
    logic [2:0] infl;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drv(input logic [1:0] av, input logic sarr, input logic srv, input logic [1:0] rr);
    if_rr.M_ARVALID = av;
    if_rr.S_ARREADY = sarr;
    if_rr.S_RVALID  = srv;
    if_rr.M_RREADY  = rr;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] d [3];
    d[0] = 64'hD000_0000_0000_00D0;
    d[1] = 64'hD111_1111_1111_11D1;
    d[2] = 64'hD222_2222_2222_22D2;

    // Both masters request every cycle; the slave answers each read the cycle after its AR.
    tbl[0]  = '{2'b11, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 3'd0};
    tbl[1]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'd0};
    tbl[2]  = '{2'b11, 1'b1, 2'b10, 2'b01, 2'b01, 2'b01, 1'b0, 3'd1};
    tbl[3]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'd0};
    tbl[4]  = '{2'b11, 1'b1, 2'b01, 2'b01, 2'b10, 2'b01, 1'b0, 3'd1};
    tbl[5]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'd0};
    tbl[6]  = '{2'b11, 1'b1, 2'b10, 2'b01, 2'b01, 2'b01, 1'b0, 3'd1};
    tbl[7]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'd0};
    tbl[8]  = '{2'b11, 1'b1, 2'b01, 2'b01, 2'b10, 2'b01, 1'b0, 3'd1};
    tbl[9]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'd0};
    tbl[10] = '{2'b11, 1'b1, 2'b10, 2'b01, 2'b01, 2'b01, 1'b0, 3'd1};
    tbl[11] = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'd0};
    tbl[12] = '{2'b00, 1'b1, 2'b00, 2'b00, 2'b10, 2'b01, 1'b0, 3'd1};
    tbl[13] = '{2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0};

    if_rr.M_ARADDR = {A1, A0};
    if_rr.S_RDATA  = 64'h0;
    if_rr.S_RRESP  = RESP_OKAY;
    drv(2'b11, 1'b1, 1'b0, 2'b11);

    // Reset values, with a request pending to show no grant leaks through.
    #12;
    chk("rst_s_arvalid", {63'd0, if_rr.S_ARVALID}, 64'd0);
    chk("rst_s_araddr", {32'd0, if_rr.S_ARADDR}, 64'd0);
    chk("rst_m_arready", {62'd0, if_rr.M_ARREADY}, 64'd0);
    chk("rst_m_rvalid", {62'd0, if_rr.M_RVALID}, 64'd0);
    chk("rst_s_rready", {63'd0, if_rr.S_RREADY}, 64'd0);
    chk("rst_inflight", {61'd0, infl_rr}, 64'd0);
    chk("rst_rd_err", {63'd0, err_rr}, 64'd0);
    drv(2'b00, 1'b1, 1'b0, 2'b11);
    nxt();
    rst_n = 1'b1;
    nxt();

    // Cycle table: RR grants 0,1,0,1,0,1; fixed grants M0 every time.
    for (int i = 0; i < 14; i++) begin
      drv(tbl[i].av, 1'b1, tbl[i].srv, 2'b11);
      #1;
      chk($sformatf("tbl%0d_arready_rr", i), {62'd0, if_rr.M_ARREADY}, {62'd0, tbl[i].ar_rr});
      chk($sformatf("tbl%0d_arready_fx", i), {62'd0, if_fx.M_ARREADY}, {62'd0, tbl[i].ar_fx});
      chk($sformatf("tbl%0d_rvalid_rr", i), {62'd0, if_rr.M_RVALID}, {62'd0, tbl[i].rv_rr});
      chk($sformatf("tbl%0d_rvalid_fx", i), {62'd0, if_fx.M_RVALID}, {62'd0, tbl[i].rv_fx});
      chk($sformatf("tbl%0d_s_arvalid", i), {63'd0, if_rr.S_ARVALID}, {63'd0, tbl[i].s_arv});
      chk($sformatf("tbl%0d_inflight", i), {61'd0, infl_rr}, {61'd0, tbl[i].infl});
      if (tbl[i].s_arv) begin
        chk($sformatf("tbl%0d_araddr_fx", i), {32'd0, if_fx.S_ARADDR}, {32'd0, A0});
        chk($sformatf("tbl%0d_araddr_rr", i), {32'd0, if_rr.S_ARADDR},
            {32'd0, ((i % 4) == 1) ? A0 : A1});
      end
      nxt();
    end
    chk("tbl_rd_err", {63'd0, err_rr}, 64'd0);

    // Single master; ARVALID drops after the grant, the latched address must hold.
    if_rr.M_ARADDR = {A1, 32'h8000_0000};
    drv(2'b01, 1'b1, 1'b0, 2'b11);
    #1;
    chk("single_arready_c0", {62'd0, if_rr.M_ARREADY}, 64'd1);
    chk("single_s_arvalid_c0", {63'd0, if_rr.S_ARVALID}, 64'd0);
    nxt();
    drv(2'b00, 1'b1, 1'b0, 2'b11);
    #1;
    chk("single_s_arvalid_c1", {63'd0, if_rr.S_ARVALID}, 64'd1);
    chk("single_s_araddr_c1", {32'd0, if_rr.S_ARADDR}, 64'h8000_0000);
    chk("single_arready_c1", {62'd0, if_rr.M_ARREADY}, 64'd0);
    nxt();
    if_rr.S_RDATA = 64'h1122_3344_5566_7788;
    if_rr.S_RRESP = RESP_SLVERR;
    drv(2'b00, 1'b1, 1'b1, 2'b11);
    #1;
    chk("single_rvalid", {62'd0, if_rr.M_RVALID}, 64'b01);
    chk("single_rdata_m0", if_rr.M_RDATA[63:0], 64'h1122_3344_5566_7788);
    chk("single_rdata_m1", if_rr.M_RDATA[127:64], 64'h1122_3344_5566_7788);
    chk("single_rresp", {60'd0, if_rr.M_RRESP}, {60'd0, RESP_SLVERR, RESP_SLVERR});
    chk("single_s_rready", {63'd0, if_rr.S_RREADY}, 64'd1);
    chk("single_inflight", {61'd0, infl_rr}, 64'd1);
    nxt();
    drv(2'b00, 1'b1, 1'b0, 2'b11);
    if_rr.S_RRESP = RESP_OKAY;
    #1;
    chk("single_inflight_done", {61'd0, infl_rr}, 64'd0);
    nxt();

    // Full FIFO: four grants, then the fifth waits until one read retires.
    if_rr.M_ARADDR = {A1, A0};
    for (int c = 0; c < 8; c++) begin
      drv(2'b01, 1'b1, 1'b0, 2'b11);
      #1;
      chk($sformatf("full_fill%0d_arready", c), {62'd0, if_rr.M_ARREADY},
          (c % 2 == 0) ? 64'd1 : 64'd0);
      nxt();
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("full_wait%0d_arready", c), {62'd0, if_rr.M_ARREADY}, 64'd0);
      chk($sformatf("full_wait%0d_inflight", c), {61'd0, infl_rr}, 64'd4);
      chk($sformatf("full_wait%0d_s_arvalid", c), {63'd0, if_rr.S_ARVALID}, 64'd0);
      nxt();
    end
    drv(2'b01, 1'b1, 1'b1, 2'b11);
    #1;
    chk("full_pop_arready", {62'd0, if_rr.M_ARREADY}, 64'd0);
    chk("full_pop_rvalid", {62'd0, if_rr.M_RVALID}, 64'b01);
    nxt();
    drv(2'b01, 1'b1, 1'b0, 2'b11);
    #1;
    chk("full_5th_arready", {62'd0, if_rr.M_ARREADY}, 64'd1);
    chk("full_5th_inflight", {61'd0, infl_rr}, 64'd3);
    nxt();
    drv(2'b00, 1'b1, 1'b0, 2'b11);
    nxt();
    for (int c = 0; c < 4; c++) begin
      drv(2'b00, 1'b1, 1'b1, 2'b11);
      #1;
      chk($sformatf("full_drain%0d_inflight", c), {61'd0, infl_rr}, 64'(4 - c));
      nxt();
    end
    drv(2'b00, 1'b1, 1'b0, 2'b11);
    #1;
    chk("full_drained", {61'd0, infl_rr}, 64'd0);
    nxt();

    // In-order routing: AR order M1, M0, M1; M1 stalls the first response.
    for (int g = 0; g < 3; g++) begin
      drv((g == 1) ? 2'b01 : 2'b10, 1'b1, 1'b0, 2'b11);
      #1;
      chk($sformatf("ord_grant%0d", g), {62'd0, if_rr.M_ARREADY}, (g == 1) ? 64'b01 : 64'b10);
      nxt();
      drv(2'b00, 1'b1, 1'b0, 2'b11);
      nxt();
    end
    if_rr.S_RDATA = d[0];
    for (int c = 0; c < 3; c++) begin
      drv(2'b00, 1'b1, 1'b1, 2'b01);
      #1;
      chk($sformatf("ord_stall%0d_s_rready", c), {63'd0, if_rr.S_RREADY}, 64'd0);
      chk($sformatf("ord_stall%0d_rvalid", c), {62'd0, if_rr.M_RVALID}, 64'b10);
      chk($sformatf("ord_stall%0d_rdata", c), if_rr.M_RDATA[127:64], d[0]);
      chk($sformatf("ord_stall%0d_inflight", c), {61'd0, infl_rr}, 64'd3);
      nxt();
    end
    for (int b = 0; b < 3; b++) begin
      if_rr.S_RDATA = d[b];
      drv(2'b00, 1'b1, 1'b1, 2'b11);
      #1;
      chk($sformatf("ord_beat%0d_rvalid_rr", b), {62'd0, if_rr.M_RVALID}, (b == 1) ? 64'b01 : 64'b10);
      chk($sformatf("ord_beat%0d_rvalid_fx", b), {62'd0, if_fx.M_RVALID}, (b == 1) ? 64'b01 : 64'b10);
      chk($sformatf("ord_beat%0d_s_rready", b), {63'd0, if_rr.S_RREADY}, 64'd1);
      chk($sformatf("ord_beat%0d_rdata", b), (b == 1) ? if_rr.M_RDATA[63:0] : if_rr.M_RDATA[127:64], d[b]);
      nxt();
    end
    drv(2'b00, 1'b1, 1'b0, 2'b11);
    #1;
    chk("ord_inflight_done", {61'd0, infl_rr}, 64'd0);
    nxt();

    // Push and pop in the same cycle at count 2.
    drv(2'b01, 1'b1, 1'b0, 2'b11); nxt();
    drv(2'b00, 1'b1, 1'b0, 2'b11); nxt();
    drv(2'b10, 1'b1, 1'b0, 2'b11); nxt();
    drv(2'b00, 1'b1, 1'b0, 2'b11); nxt();
    drv(2'b01, 1'b1, 1'b0, 2'b11);
    #1;
    chk("pp_grant", {62'd0, if_rr.M_ARREADY}, 64'b01);
    chk("pp_inflight_pre", {61'd0, infl_rr}, 64'd2);
    nxt();
    drv(2'b00, 1'b1, 1'b1, 2'b11);
    #1;
    chk("pp_s_arvalid", {63'd0, if_rr.S_ARVALID}, 64'd1);
    chk("pp_rvalid", {62'd0, if_rr.M_RVALID}, 64'b01);
    nxt();
    drv(2'b00, 1'b1, 1'b0, 2'b11);
    #1;
    chk("pp_inflight_post", {61'd0, infl_rr}, 64'd2);
    nxt();
    drv(2'b00, 1'b1, 1'b1, 2'b11);
    #1;
    chk("pp_route0", {62'd0, if_rr.M_RVALID}, 64'b10);
    nxt();
    #1;
    chk("pp_route1", {62'd0, if_rr.M_RVALID}, 64'b01);
    nxt();
    drv(2'b00, 1'b1, 1'b0, 2'b11);
    #1;
    chk("pp_inflight_done", {61'd0, infl_rr}, 64'd0);
    nxt();

    // Reset mid-flight: three reads outstanding and a fourth AR held by the slave.
    for (int g = 0; g < 3; g++) begin
      drv(2'b01, 1'b1, 1'b0, 2'b11); nxt();
      drv(2'b00, 1'b1, 1'b0, 2'b11); nxt();
    end
    drv(2'b01, 1'b0, 1'b0, 2'b11); nxt();
    #1;
    chk("mid_s_arvalid_pre", {63'd0, if_rr.S_ARVALID}, 64'd1);
    chk("mid_inflight_pre", {61'd0, infl_rr}, 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_s_arvalid_rst", {63'd0, if_rr.S_ARVALID}, 64'd0);
    chk("mid_inflight_rst", {61'd0, infl_rr}, 64'd0);
    chk("mid_arready_rst", {62'd0, if_rr.M_ARREADY}, 64'd0);
    nxt();
    rst_n = 1'b1;
    drv(2'b00, 1'b1, 1'b1, 2'b11);
    #1;
    chk("mid_stray_rvalid", {62'd0, if_rr.M_RVALID}, 64'd0);
    chk("mid_stray_s_rready", {63'd0, if_rr.S_RREADY}, 64'd0);
    chk("mid_err_before", {63'd0, err_rr}, 64'd0);
    nxt();
    drv(2'b00, 1'b1, 1'b0, 2'b11);
    #1;
    chk("mid_err_set_rr", {63'd0, err_rr}, 64'd1);
    chk("mid_err_set_fx", {63'd0, err_fx}, 64'd1);
    nxt();
    nxt();
    #1;
    chk("mid_err_sticky", {63'd0, err_rr}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
